// File: rtl/bc_broadcast_source.sv
// Transmit end of the inter-lane broadcast chain: buffers operand words from the source in a
// small FIFO and hands them to lane 0, counting words in and out per command.
module bc_broadcast_source #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [CntWidth-1:0] cmd_len_i,
  input  logic                src_valid_i,
  input  logic [63:0]         src_data_i,
  output logic                src_ready_o,
  output logic                bc_valid_o,
  output logic [63:0]         bc_data_o,
  input  logic                bc_ready_i,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;
  localparam logic [CntWidth-1:0] CntOne = 1;

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] in_cnt_q, in_cnt_d;
  logic [CntWidth-1:0] out_cnt_q, out_cnt_d;
  logic                done_q, done_d;
  logic [63:0]         mem_q [DEPTH];
  logic [PtrW:0]       wr_ptr_q, rd_ptr_q;
  logic                fifo_empty, fifo_full, push, pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  end

  always_comb begin
    cmd_ready_o = (state_q == StIdle);
    src_ready_o = (state_q == StStream) && !fifo_full && (in_cnt_q != '0);
    bc_valid_o  = !fifo_empty;
    bc_data_o   = mem_q[rd_ptr_q[PtrW-1:0]];
    busy_o      = (state_q != StIdle);
    done_o      = done_q;
    push        = src_valid_i && src_ready_o;
    pop         = bc_valid_o && bc_ready_i;
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            done_d = 1'b1;
          end else begin
            in_cnt_d  = cmd_len_i;
            out_cnt_d = cmd_len_i;
            state_d   = StStream;
          end
        end
      end
      StStream: begin
        if (push) begin
          in_cnt_d = in_cnt_q - CntOne;
          if (in_cnt_q == CntOne) state_d = StDrain;
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase
    // The final pop ends the command regardless of which busy state we are in.
    if (pop && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - CntOne;
      if (out_cnt_q == CntOne) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      done_q    <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PtrW-1:0]] <= src_data_i;
  end

endmodule

// File: tb/tb_bc_broadcast_source.sv
// Directed bench for bc_broadcast_source: inputs driven and outputs sampled on the falling edge.
module tb_bc_broadcast_source;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [15:0] cmd_len_i;
  logic        src_valid_i;
  logic [63:0] src_data_i;
  logic        src_ready_o;
  logic        bc_valid_o;
  logic [63:0] bc_data_o;
  logic        bc_ready_i;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;
  int n_src    = 0;
  bit rand_mode = 1'b0;
  logic [63:0] src_q[$];
  logic [63:0] rx_q[$];
  logic [63:0] exp_q[$];

  bc_broadcast_source #(
    .DEPTH   (4),
    .CntWidth(16)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_len_i  (cmd_len_i),
    .src_valid_i(src_valid_i),
    .src_data_i (src_data_i),
    .src_ready_o(src_ready_o),
    .bc_valid_o (bc_valid_o),
    .bc_data_o  (bc_data_o),
    .bc_ready_i (bc_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    src_valid_i = (src_q.size() != 0) && (!rand_mode || ($urandom_range(0, 1) == 1));
    src_data_i  = (src_q.size() != 0) ? src_q[0] : 64'd0;
    if (rand_mode) bc_ready_i = ($urandom_range(0, 1) == 1);
  endtask

  // Advance one clock: record handshakes seen in the current cycle, then move to the next.
  task automatic tick();
    logic s_hs, b_hs, c_hs;
    s_hs = src_valid_i && src_ready_o;
    b_hs = bc_valid_o && bc_ready_i;
    c_hs = cmd_valid_i && cmd_ready_o;
    if (b_hs) rx_q.push_back(bc_data_o);
    if (done_o) n_done++;
    if (s_hs) n_src++;
    @(negedge clk_i);
    if (s_hs) void'(src_q.pop_front());
    if (c_hs) cmd_valid_i = 1'b0;
    drive_src();
  endtask

  task automatic wait_done(input string tag, input int budget);
    int i;
    i = 0;
    while (!done_o && i < budget) begin
      tick();
      i++;
    end
    check(tag, 64'(done_o), 64'd1);
  endtask

  task automatic compare_rx(input string tag);
    int errs;
    errs = 0;
    check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      if (rx_q[i] !== exp_q[i]) errs++;
    end
    check({tag, "_order"}, 64'(errs), 64'd0);
  endtask

  initial begin
    int base_done, base_src;
    logic [63:0] w;
    rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_len_i = '0;
    src_valid_i = 1'b0; src_data_i = '0; bc_ready_i = 1'b0;
    @(negedge clk_i);
    tick();
    tick();
    rst_i = 1'b0;
    check("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("rst_src_ready", 64'(src_ready_o), 64'd0);
    check("rst_bc_valid",  64'(bc_valid_o),  64'd0);
    check("rst_busy",      64'(busy_o),      64'd0);
    check("rst_done",      64'(done_o),      64'd0);

    // len=4, both sides always ready
    rx_q.delete(); base_done = n_done;
    for (int k = 0; k < 4; k++) src_q.push_back(64'hA0 + 64'(k));
    bc_ready_i = 1'b1; drive_src();
    cmd_len_i = 16'd4; cmd_valid_i = 1'b1;
    check("a_cmd_ready", 64'(cmd_ready_o), 64'd1);
    for (int c = 1; c <= 7; c++) begin
      tick();
      check("a_busy",  64'(busy_o),     (c <= 5) ? 64'd1 : 64'd0);
      check("a_valid", 64'(bc_valid_o), (c >= 2 && c <= 5) ? 64'd1 : 64'd0);
      if (c >= 2 && c <= 5) check("a_data", bc_data_o, 64'hA0 + 64'(c - 2));
      check("a_done",  64'(done_o),     (c == 6) ? 64'd1 : 64'd0);
    end
    check("a_done_cnt", 64'(n_done - base_done), 64'd1);

    // len=8 with a 10-cycle lane stall
    rx_q.delete(); exp_q.delete(); base_src = n_src;
    for (int k = 0; k < 8; k++) begin
      src_q.push_back(64'hB0 + 64'(k));
      exp_q.push_back(64'hB0 + 64'(k));
    end
    drive_src();
    cmd_len_i = 16'd8; cmd_valid_i = 1'b1;
    tick(); tick(); tick();
    bc_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("b_stall_valid", 64'(bc_valid_o), 64'd1);
      check("b_stall_data",  bc_data_o,       64'hB1);
      tick();
    end
    check("b_full_src_ready", 64'(src_ready_o), 64'd0);
    check("b_pushed_while_full", 64'(n_src - base_src), 64'd5);
    bc_ready_i = 1'b1;
    wait_done("b_done", 100);
    tick();
    compare_rx("b_rx");

    // len=0 completes without touching the source or the lane
    base_src = n_src; base_done = n_done;
    src_q.push_back(64'hC0); drive_src();
    cmd_len_i = 16'd0; cmd_valid_i = 1'b1;
    tick();
    check("c_done",      64'(done_o),      64'd1);
    check("c_busy",      64'(busy_o),      64'd0);
    check("c_bc_valid",  64'(bc_valid_o),  64'd0);
    check("c_src_ready", 64'(src_ready_o), 64'd0);
    tick();
    check("c_done_low", 64'(done_o), 64'd0);
    tick();
    check("c_no_src", 64'(n_src - base_src), 64'd0);
    check("c_done_cnt", 64'(n_done - base_done), 64'd1);
    src_q.delete(); drive_src();

    // back-to-back len=3 then len=2, source offers 6 words
    rx_q.delete(); exp_q.delete(); base_src = n_src;
    for (int k = 0; k < 6; k++) src_q.push_back(64'hD0 + 64'(k));
    for (int k = 0; k < 5; k++) exp_q.push_back(64'hD0 + 64'(k));
    drive_src();
    cmd_len_i = 16'd3; cmd_valid_i = 1'b1;
    tick();
    wait_done("d_done1", 50);
    check("d_cmd_ready_in_done", 64'(cmd_ready_o), 64'd1);
    cmd_len_i = 16'd2; cmd_valid_i = 1'b1;
    tick();
    check("d_second_busy", 64'(busy_o), 64'd1);
    wait_done("d_done2", 50);
    tick(); tick(); tick();
    check("d_src_ready_idle", 64'(src_ready_o), 64'd0);
    check("d_consumed", 64'(n_src - base_src), 64'd5);
    check("d_left", 64'(src_q.size()), 64'd1);
    compare_rx("d_rx");
    src_q.delete(); drive_src();

    // reset mid-command with two words buffered
    base_done = n_done;
    bc_ready_i = 1'b0;
    src_q.push_back(64'hE0); src_q.push_back(64'hE1); drive_src();
    cmd_len_i = 16'd5; cmd_valid_i = 1'b1;
    tick(); tick(); tick();
    check("e_pre_valid", 64'(bc_valid_o), 64'd1);
    check("e_pre_data",  bc_data_o,       64'hE0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("e_bc_valid",  64'(bc_valid_o),  64'd0);
    check("e_busy",      64'(busy_o),      64'd0);
    check("e_cmd_ready", 64'(cmd_ready_o), 64'd1);
    check("e_done",      64'(done_o),      64'd0);
    tick(); tick(); tick();
    check("e_no_done", 64'(n_done - base_done), 64'd0);

    // len=1000 with random valid/ready
    rx_q.delete(); exp_q.delete(); src_q.delete(); base_done = n_done;
    for (int k = 0; k < 1000; k++) begin
      w = {$urandom(), $urandom()};
      src_q.push_back(w);
      exp_q.push_back(w);
    end
    rand_mode = 1'b1; drive_src();
    cmd_len_i = 16'd1000; cmd_valid_i = 1'b1;
    wait_done("f_done", 20000);
    rand_mode = 1'b0;
    tick(); tick(); tick();
    compare_rx("f_rx");
    check("f_done_cnt", 64'(n_done - base_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
